// File: rtl/meter_pkg.sv
// Shared widths, FSM state encoding and the shift/saturate helper for the
// meter power scheduler.
`timescale 1ns/1ps
package meter_pkg;

  localparam int unsigned V_W    = 22;
  localparam int unsigned I_W    = 22;
  localparam int unsigned P_W    = 36;
  localparam int unsigned PROD_W = 44;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StTrig   = 3'd1,
    StWaitHi = 3'd2,
    StWaitLo = 3'd3,
    StMult   = 3'd4,
    StSat    = 3'd5,
    StOut    = 3'd6
  } state_e;

  // Returns {saturated, power}; any bit surviving above P_W after the shift saturates.
  function automatic logic [P_W:0] sat_shift(input logic [PROD_W-1:0] prod,
                                             input int unsigned shift);
    logic [PROD_W-1:0] s;
    s = prod >> shift;
    if (|(s >> P_W)) begin
      return {1'b1, {P_W{1'b1}}};
    end
    return {1'b0, s[P_W-1:0]};
  endfunction

endpackage

// File: rtl/seq_mult_u22.sv
// Unsigned 22x22->44 shift-add multiplier; one multiplier bit per clock,
// o_done pulses 22 clocks after i_start is sampled.
`timescale 1ns/1ps
module seq_mult_u22
  import meter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [V_W-1:0]    i_a,
  input  logic [I_W-1:0]    i_b,
  output logic              o_done,
  output logic [PROD_W-1:0] o_prod
);

  localparam int unsigned CNT_W = $clog2(I_W);

  logic [PROD_W-1:0] r_mcand;
  logic [I_W-1:0]    r_mplier;
  logic [PROD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_mcand  <= {{(PROD_W-V_W){1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(I_W-1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/meter_power_sched.sv
// Periodically triggers the V/I meter, captures its result, computes scaled
// saturated power and offers {V,I,P} on a valid/ready interface.
`timescale 1ns/1ps
module meter_power_sched
  import meter_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 1000000,
  parameter int unsigned P_SHIFT       = 8,
  parameter int unsigned BUSY_TIMEOUT  = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  output logic           o_meter_start,
  input  logic           i_meter_busy,
  input  logic [V_W-1:0] i_meter_v,
  input  logic [I_W-1:0] i_meter_i,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [V_W-1:0] o_out_v,
  output logic [I_W-1:0] o_out_i,
  output logic [P_W-1:0] o_out_p,
  output logic           o_p_sat,
  output logic           o_overrun,
  output logic           o_timeout_err
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT + 1);

  logic [CNT_W-1:0]  r_period_cnt;
  logic              w_tick;
  state_e            r_state;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_start;
  logic              r_valid;
  logic [V_W-1:0]    r_v;
  logic [I_W-1:0]    r_i;
  logic [P_W-1:0]    r_p;
  logic              r_p_sat;
  logic              r_overrun;
  logic              r_timeout;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [PROD_W-1:0] w_prod;

  // Counter parks at 0 while disabled so re-enabling gives a full period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period_cnt <= '0;
    end else if (!i_enable) begin
      r_period_cnt <= '0;
    end else if (r_period_cnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  assign w_tick = i_enable && (r_period_cnt == CNT_W'(SAMPLE_PERIOD - 1));

  // Multiplier is fed straight from the meter bus in the capture cycle.
  assign w_mul_start = (r_state == StWaitLo) && !i_meter_busy;

  seq_mult_u22 u_mult (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_mul_start),
    .i_a     (i_meter_v),
    .i_b     (i_meter_i),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_to_cnt  <= '0;
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_v       <= '0;
      r_i       <= '0;
      r_p       <= '0;
      r_p_sat   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_tick) begin
            r_start <= 1'b1;
            r_state <= StTrig;
          end
        end
        StTrig: begin
          r_to_cnt <= '0;
          r_state  <= StWaitHi;
        end
        StWaitHi: begin
          if (i_meter_busy) begin
            r_state <= StWaitLo;
          end else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        StWaitLo: begin
          if (!i_meter_busy) begin
            r_v     <= i_meter_v;
            r_i     <= i_meter_i;
            r_state <= StMult;
          end
        end
        StMult: begin
          if (w_mul_done) begin
            r_state <= StSat;
          end
        end
        StSat: begin
          {r_p_sat, r_p} <= sat_shift(w_prod, P_SHIFT);
          r_valid        <= 1'b1;
          r_state        <= StOut;
        end
        StOut: begin
          if (i_out_ready) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_meter_start = r_start;
  assign o_out_valid   = r_valid;
  assign o_out_v       = r_v;
  assign o_out_i       = r_i;
  assign o_out_p       = r_p;
  assign o_p_sat       = r_p_sat;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout;

endmodule
